// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game datapath: the 2-bit symbol encoding
// used by both the display and input-checking paths, verdict codes and the
// input-checker state encoding.
package genius_pkg;

  typedef logic [1:0] symbol_t;

  localparam symbol_t SYM_BT0  = 2'b00;
  localparam symbol_t SYM_BT1  = 2'b01;
  localparam symbol_t SYM_BT2  = 2'b10;
  localparam symbol_t SYM_NONE = 2'b11;  // stored filler, never matches a button

  typedef logic [1:0] fail_code_t;

  localparam fail_code_t FC_NONE    = 2'b00;
  localparam fail_code_t FC_WRONG   = 2'b01;
  localparam fail_code_t FC_TIMEOUT = 2'b10;
  localparam fail_code_t FC_MULTI   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

  // Symbol for a single-button press vector; only meaningful when one bit is set.
  function automatic symbol_t press_to_symbol(input logic [2:0] press);
    symbol_t sym;
    sym = SYM_BT0;
    if (press[1]) sym = SYM_BT1;
    if (press[2]) sym = SYM_BT2;
    return sym;
  endfunction

  // True when two or more buttons produced a press event in the same cycle.
  function automatic logic multi_press(input logic [2:0] press);
    return (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
  endfunction

endpackage

// File: rtl/genius_btn_sync.sv
// Brings the three raw buttons into the clock domain and turns rising edges
// of the synchronized levels into single-cycle press events.
module genius_btn_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn,
  output logic [2:0] press,
  output logic       any_held
);

  logic [2:0] meta;
  logic [2:0] synced;
  logic [2:0] prev;

  // Two-flop synchronizer followed by a one-cycle-delayed copy for edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta   <= '0;
      synced <= '0;
      prev   <= '0;
    end else begin
      meta   <= btn;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign press    = synced & ~prev;
  assign any_held = |synced;

endmodule

// File: rtl/genius_input_checker.sv
// Receives player button presses and checks them one at a time against the
// stored sequence, ending each round with a one-cycle pass or fail pulse.
//
//   state           | meaning
//   ----------------+------------------------------------------------------
//   ST_IDLE         | no round in progress, waiting for start
//   ST_WAIT_PRESS   | expecting the next press, per-press timer running
//   ST_WAIT_RELEASE | entry matched, waiting for all buttons to be released
//
// The per-press timer is a down-counter loaded with TIMEOUT_CYCLES-1; reaching
// zero on a cycle that still has no resolution is the timeout.
module genius_input_checker
  import genius_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 50_000_000,
  parameter  int SEQ_LEN        = 16,
  localparam int IDX_W          = $clog2(SEQ_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] level,
  input  logic             bt0,
  input  logic             bt1,
  input  logic             bt2,
  output logic [IDX_W-1:0] seq_addr,
  input  logic [1:0]       seq_data,
  output logic             busy,
  output logic [IDX_W-1:0] progress,
  output logic [1:0]       last_symbol,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  logic [2:0] press;
  logic       any_held;

  genius_btn_sync u_btn_sync (
    .clock    (clock),
    .reset    (reset),
    .btn      ({bt2, bt1, bt0}),
    .press    (press),
    .any_held (any_held)
  );

  state_t             state,       state_n;
  logic [TIMER_W-1:0] timer,       timer_n;
  logic [IDX_W-1:0]   lvl_q,       lvl_n;
  logic [IDX_W-1:0]   seq_addr_n;
  logic [IDX_W-1:0]   progress_n;
  symbol_t            last_sym_n;
  logic               pass_n,      fail_n;
  fail_code_t         fail_code_n;

  logic    timer_expired;
  symbol_t press_sym;

  assign timer_expired = (timer == '0);
  assign press_sym     = press_to_symbol(press);
  assign busy          = (state != ST_IDLE);

  // State and round-status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      lvl_q       <= '0;
      seq_addr    <= '0;
      progress    <= '0;
      last_symbol <= SYM_BT0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= FC_NONE;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      lvl_q       <= lvl_n;
      seq_addr    <= seq_addr_n;
      progress    <= progress_n;
      last_symbol <= last_sym_n;
      pass        <= pass_n;
      fail        <= fail_n;
      fail_code   <= fail_code_n;
    end
  end

  // Next-state and verdict decisions; pulses default low every cycle.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    lvl_n       = lvl_q;
    seq_addr_n  = seq_addr;
    progress_n  = progress;
    last_sym_n  = last_symbol;
    pass_n      = 1'b0;
    fail_n      = 1'b0;
    fail_code_n = fail_code;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          lvl_n       = level;
          progress_n  = '0;
          seq_addr_n  = '0;
          timer_n     = TIMER_LOAD;
          fail_code_n = FC_NONE;
          state_n     = ST_WAIT_PRESS;
        end
      end

      ST_WAIT_PRESS: begin
        if (press == 3'b000) begin
          if (timer_expired) begin
            fail_n      = 1'b1;
            fail_code_n = FC_TIMEOUT;
            state_n     = ST_IDLE;
          end else begin
            timer_n = timer - TIMER_ONE;
          end
        end else if (multi_press(press)) begin
          fail_n      = 1'b1;
          fail_code_n = FC_MULTI;
          state_n     = ST_IDLE;
        end else begin
          last_sym_n = press_sym;
          if (press_sym != seq_data) begin
            fail_n      = 1'b1;
            fail_code_n = FC_WRONG;
            state_n     = ST_IDLE;
          end else if (progress == lvl_q) begin
            // Final entry: progress wraps at full depth, pass is the real flag.
            pass_n     = 1'b1;
            progress_n = progress + IDX_ONE;
            state_n    = ST_IDLE;
          end else begin
            progress_n = progress + IDX_ONE;
            seq_addr_n = seq_addr + IDX_ONE;
            timer_n    = TIMER_LOAD;
            state_n    = ST_WAIT_RELEASE;
          end
        end
      end

      ST_WAIT_RELEASE: begin
        // A clean release wins over a timeout landing on the same cycle.
        if (!any_held) begin
          timer_n = TIMER_LOAD;
          state_n = ST_WAIT_PRESS;
        end else if (timer_expired) begin
          fail_n      = 1'b1;
          fail_code_n = FC_TIMEOUT;
          state_n     = ST_IDLE;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_genius_input_checker.sv
// Self-checking bench for genius_input_checker: directed scenarios with
// hand-computed expectations, then randomized rounds checked every cycle
// against a round-level behavioural model.
module tb_genius_input_checker;
  import genius_pkg::*;

  localparam int T       = 20;
  localparam int SEQ_LEN = 16;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [3:0] level;
  logic       bt0, bt1, bt2;
  logic [3:0] seq_addr;
  logic [1:0] seq_data;
  logic       busy;
  logic [3:0] progress;
  logic [1:0] last_symbol;
  logic       pass, fail;
  logic [1:0] fail_code;

  logic [1:0] mem [SEQ_LEN];
  assign seq_data = mem[seq_addr];

  genius_input_checker #(.TIMEOUT_CYCLES(T), .SEQ_LEN(SEQ_LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .level       (level),
    .bt0         (bt0),
    .bt1         (bt1),
    .bt2         (bt2),
    .seq_addr    (seq_addr),
    .seq_data    (seq_data),
    .busy        (busy),
    .progress    (progress),
    .last_symbol (last_symbol),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Round view: phase 0 = no round, 1 = awaiting a press, 2 = awaiting release.
  // A button is seen as pressed two edges after it is first sampled high,
  // provided it was sampled low on the edge before that.
  logic       m_valid = 1'b0;
  int         m_phase, m_elapsed, m_lvl, m_prog, m_addr, m_last, m_code;
  logic       m_pass, m_fail;
  logic [2:0] hist [3];   // raw samples: [0] last edge, [1] two ago, [2] three ago

  task automatic m_lose(input int code);
    m_fail  = 1'b1;
    m_code  = code;
    m_phase = 0;
  endtask

  always @(posedge clock) begin : model
    logic [2:0] raw, ev;
    int         sym;
    raw = {bt2, bt1, bt0};
    if (reset) begin
      m_valid = 1'b1;
      m_phase = 0; m_elapsed = 0; m_lvl = 0; m_prog = 0; m_addr = 0;
      m_last = 0; m_code = 0; m_pass = 1'b0; m_fail = 1'b0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      ev     = hist[1] & ~hist[2];
      m_pass = 1'b0;
      m_fail = 1'b0;
      case (m_phase)
        0: if (start) begin
             m_lvl = int'(level); m_prog = 0; m_addr = 0; m_elapsed = 0;
             m_code = 0; m_phase = 1;
           end
        1: begin
             if ($countones(ev) == 0) begin
               if (m_elapsed == T - 1) m_lose(2);
               else m_elapsed++;
             end else if ($countones(ev) > 1) begin
               m_lose(3);
             end else begin
               sym    = ev[0] ? 0 : (ev[1] ? 1 : 2);
               m_last = sym;
               if (sym != int'(mem[m_prog])) m_lose(1);
               else if (m_prog == m_lvl) begin
                 m_pass  = 1'b1;
                 m_prog  = (m_prog + 1) % SEQ_LEN;
                 m_phase = 0;
               end else begin
                 m_prog++; m_addr++; m_elapsed = 0; m_phase = 2;
               end
             end
           end
        default: begin
             if (hist[1] == 3'b000) begin
               m_elapsed = 0; m_phase = 1;
             end else if (m_elapsed == T - 1) m_lose(2);
             else m_elapsed++;
           end
      endcase
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = raw;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      check("busy",        busy,        int'(m_phase != 0));
      check("pass",        pass,        m_pass);
      check("fail",        fail,        m_fail);
      check("fail_code",   fail_code,   m_code);
      check("progress",    progress,    m_prog);
      check("last_symbol", last_symbol, m_last);
      check("seq_addr",    seq_addr,    m_addr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_btn(input logic [2:0] b);
    {bt2, bt1, bt0} = b;
  endtask

  task automatic do_start(input int lv);
    @(negedge clock);
    level = 4'(lv);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int gap);
    set_btn(b);
    cyc(hold);
    set_btn(3'b000);
    cyc(gap);
  endtask

  // Counts negedges until a verdict pulse shows; start is dropped after the first.
  task automatic wait_verdict(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      @(negedge clock);
      start = 1'b0;
      cnt++;
      if (pass || fail) break;
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clock);
      n++;
    end
    check("round_idle", busy, 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cnt, lv, hold, gap;
    logic [2:0] b;
    reset = 1'b1; start = 1'b0; level = '0; set_btn(3'b000);
    for (int i = 0; i < SEQ_LEN; i++) mem[i] = SYM_NONE;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_busy", busy, 0);
    check("rst_code", fail_code, 0);
    check("rst_addr", seq_addr, 0);

    // Four-entry round matched in full.
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd0; mem[3] = 2'd1;
    do_start(3);
    press(3'b001, 2, 2);
    press(3'b010, 2, 2);
    press(3'b001, 2, 2);
    set_btn(3'b010);
    wait_verdict(40, cnt);
    check("t1_latency", cnt, 3);
    check("t1_pass", pass, 1);
    check("t1_fail", fail, 0);
    set_btn(3'b000);
    cyc(1);
    check("t1_progress", progress, 4);
    check("t1_code", fail_code, 0);
    cyc(2);

    // Wrong symbol on the second entry.
    mem[0] = 2'd0; mem[1] = 2'd2;
    do_start(1);
    press(3'b001, 2, 2);
    set_btn(3'b010);
    wait_verdict(40, cnt);
    check("t2_latency", cnt, 3);
    check("t2_fail", fail, 1);
    check("t2_code", fail_code, 1);
    check("t2_last", last_symbol, 1);
    check("t2_progress", progress, 1);
    press(3'b000, 1, 2);

    // No press at all: timeout.
    mem[0] = 2'd0;
    @(negedge clock);
    level = 4'd0;
    start = 1'b1;
    wait_verdict(40, cnt);
    check("t3_latency", cnt, T + 1);
    check("t3_fail", fail, 1);
    check("t3_code", fail_code, 2);
    cyc(2);

    // Two buttons rising together.
    do_start(0);
    set_btn(3'b101);
    wait_verdict(40, cnt);
    check("t4_latency", cnt, 3);
    check("t4_code", fail_code, 3);
    press(3'b000, 1, 2);

    // Long hold counts once.
    mem[0] = 2'd0; mem[1] = 2'd0;
    do_start(1);
    set_btn(3'b001);
    cyc(10);
    check("t5_progress_held", progress, 1);
    check("t5_busy_held", busy, 1);
    set_btn(3'b000);
    cyc(2);
    set_btn(3'b001);
    wait_verdict(40, cnt);
    check("t5_latency", cnt, 3);
    check("t5_pass", pass, 1);
    set_btn(3'b000);
    cyc(1);
    check("t5_progress", progress, 2);
    cyc(2);

    // Reset while waiting for release; button kept held across reset.
    mem[0] = 2'd1; mem[1] = 2'd1; mem[2] = 2'd0;
    do_start(2);
    set_btn(3'b010);
    cyc(5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_pass", pass, 0);
    check("t6_fail", fail, 0);
    check("t6_progress", progress, 0);
    check("t6_last", last_symbol, 0);
    check("t6_addr", seq_addr, 0);
    cyc(4);
    do_start(2);
    cyc(4);
    check("t6_no_event", progress, 0);
    set_btn(3'b000);
    cyc(2);
    press(3'b010, 2, 2);
    check("t6_repress", progress, 1);
    wait_idle(3 * T);
    cyc(2);

    // Randomized rounds.
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < SEQ_LEN; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      lv = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
      do_start(lv);
      for (int i = 0; i <= lv; i++) begin
        b = (mem[i] == 2'd3) ? 3'b001 : (3'b001 << mem[i]);
        case ($urandom_range(0, 24))
          0: b = 3'($urandom_range(1, 7));
          1: b = 3'b000;
          2: begin reset = 1'b1; @(negedge clock); reset = 1'b0; end
          default: ;
        endcase
        if (b == 3'b000) cyc(T + 3);
        hold = int'($urandom_range(1, 4));
        gap  = int'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) start = 1'b1;
        set_btn(b);
        cyc(hold);
        start = 1'b0;
        set_btn(3'b000);
        cyc(gap);
        if (m_phase == 0) break;
      end
      wait_idle(3 * T);
      cyc(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
